spi_frame_sequencer: RTL and testbench

- SPI peripheral-side frame controller, SPI mode 0 (CPOL=0, CPHA=0), MSB first, system-clock oversampled.
- Synchronises raw cs_n/sclk/mosi pins and derives rising/falling edge events internally (registered delay + compare, held under ena).
- Sequences per-bit shift-in/shift-out and word boundaries.
- Hands complete words to the register file via rx_valid and fetches transmit words via tx_load.

---
 rtl/spi_frame_sequencer_if.sv | 24 ++
 rtl/spi_frame_sequencer.sv | 162 ++++++++++++++++
 tb/tb_spi_frame_sequencer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_frame_sequencer_if.sv
// Register-file side of the SPI frame sequencer: transmit word fetch,
// received word hand-off and frame status.
interface spi_frame_sequencer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_load;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             frame_active;
  logic             frame_err;

  // Sequencer side
  modport master (
    input  tx_data,
    output tx_load, rx_data, rx_valid, frame_active, frame_err
  );

  // Register-file side
  modport slave (
    output tx_data,
    input  tx_load, rx_data, rx_valid, frame_active, frame_err
  );
endinterface

// File: rtl/spi_frame_sequencer.sv
// SPI mode 0 peripheral frame controller, MSB first, oversampled by clk.
// Raw pins are synchronised, edges are detected against a delay register
// held under ena, and a two-state FSM sequences bits and word boundaries.
module spi_frame_sequencer #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  spi_cs_n,
  input  logic                  spi_sclk,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  spi_frame_sequencer_if.master bus
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync, primed;
  logic                   cs_s, sclk_s, mosi_s;
  logic                   cs_dly, sclk_dly, armed;
  logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic [CNT_W-1:0]       bit_cnt, bit_cnt_n;
  logic [WIDTH-1:0]       rx_shift, rx_shift_n, tx_shift, tx_shift_n;
  logic [WIDTH-1:0]       rx_data_q, rx_data_n;
  logic                   reload_pending, reload_pending_n;
  logic                   miso_n, rx_valid_q, rx_valid_n;
  logic                   frame_err_q, frame_err_n, tx_load_c;

  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Synchronisers run regardless of ena; primed marks that the chains have
  // been flushed since reset, because cs_sync resets to the idle (high) level
  // and would otherwise look like a real deselect while a master holds cs_n low.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      primed    <= '0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      primed    <= {primed[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Edge-detect delay registers and the arm flag, frozen while ena is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_dly   <= 1'b1;
      sclk_dly <= 1'b0;
      armed    <= 1'b0;
    end else if (ena) begin
      cs_dly   <= cs_s;
      sclk_dly <= sclk_s;
      if (cs_s && primed[SYNC_STAGES-1]) armed <= 1'b1;
    end
  end

  assign sclk_rise = ena &  sclk_s & ~sclk_dly;
  assign sclk_fall = ena & ~sclk_s &  sclk_dly;
  assign cs_fall   = ena & ~cs_s   &  cs_dly;
  assign cs_rise   = ena &  cs_s   & ~cs_dly;

  // Next-state and datapath decode; cs_rise pre-empts any sclk edge.
  always_comb begin
    state_n          = state;
    bit_cnt_n        = bit_cnt;
    rx_shift_n       = rx_shift;
    tx_shift_n       = tx_shift;
    rx_data_n        = rx_data_q;
    reload_pending_n = reload_pending;
    miso_n           = spi_miso;
    rx_valid_n       = 1'b0;
    frame_err_n      = 1'b0;
    tx_load_c        = 1'b0;
    case (state)
      IDLE: begin
        miso_n = 1'b0;
        if (cs_fall && armed) begin
          state_n          = ACTIVE;
          bit_cnt_n        = '0;
          tx_shift_n       = bus.tx_data;
          tx_load_c        = 1'b1;
          reload_pending_n = 1'b0;
          miso_n           = bus.tx_data[WIDTH-1];
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_n          = IDLE;
          frame_err_n      = (bit_cnt != '0);
          bit_cnt_n        = '0;
          rx_shift_n       = '0;
          reload_pending_n = 1'b0;
          miso_n           = 1'b0;
        end else if (sclk_rise) begin
          rx_shift_n = {rx_shift[WIDTH-2:0], mosi_s};
          if (bit_cnt == LAST_BIT) begin
            rx_data_n        = rx_shift_n;
            rx_valid_n       = 1'b1;
            bit_cnt_n        = '0;
            reload_pending_n = 1'b1;
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end else if (sclk_fall) begin
          if (reload_pending) begin
            tx_shift_n       = bus.tx_data;
            tx_load_c        = 1'b1;
            reload_pending_n = 1'b0;
          end else begin
            tx_shift_n = tx_shift << 1;
          end
          miso_n = tx_shift_n[WIDTH-1];
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers; with ena low no event fires, so all hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      rx_shift       <= '0;
      tx_shift       <= '0;
      rx_data_q      <= '0;
      reload_pending <= 1'b0;
      spi_miso       <= 1'b0;
      rx_valid_q     <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      state          <= state_n;
      bit_cnt        <= bit_cnt_n;
      rx_shift       <= rx_shift_n;
      tx_shift       <= tx_shift_n;
      rx_data_q      <= rx_data_n;
      reload_pending <= reload_pending_n;
      spi_miso       <= miso_n;
      rx_valid_q     <= rx_valid_n;
      frame_err_q    <= frame_err_n;
    end
  end

  assign bus.tx_load      = tx_load_c & ~rst;
  assign bus.rx_data      = rx_data_q;
  assign bus.rx_valid     = rx_valid_q;
  assign bus.frame_err    = frame_err_q;
  assign bus.frame_active = (state == ACTIVE);

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Randomised scoreboard bench for spi_frame_sequencer: a bit-banged SPI
// master drives frames, a register-file model feeds tx words, and monitors
// compare rx words, miso words and error pulses against queued expectations.
module tb_spi_frame_sequencer;
  localparam int WIDTH       = 8;
  localparam int SYNC_STAGES = 2;

  logic clk = 1'b0;
  logic rst, ena, spi_cs_n, spi_sclk, spi_mosi, spi_miso;

  spi_frame_sequencer_if #(.WIDTH(WIDTH)) bus ();

  spi_frame_sequencer #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .spi_cs_n (spi_cs_n),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int               n_cmp = 0;
  int               n_fail = 0;
  logic [WIDTH-1:0] rx_exp[$];
  logic [WIDTH-1:0] miso_exp[$];
  logic [WIDTH-1:0] tx_q[$];
  int               err_exp[$];
  logic [WIDTH-1:0] frame_mosi[8];
  logic [WIDTH-1:0] frame_tx[8];
  logic [WIDTH-1:0] model_last_rx = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // end_mode: 0 = full words, last fall merged with cs_n rise
  //           1 = nwords full words then 'extra' rises, cs_n rises while sclk low
  //           2 = last rise of the last word coincides with cs_n rise
  task automatic applyStimulus(input int nwords, input int half, input int end_mode,
                               input int extra, input int pause_at);
    int complete, loads, total_bits, rises;
    complete = (end_mode == 2) ? nwords - 1 : nwords;
    loads    = (end_mode == 1) ? nwords + 1 : nwords;
    for (int k = 0; k < complete; k++) begin
      rx_exp.push_back(frame_mosi[k]);
      miso_exp.push_back(frame_tx[k]);
      model_last_rx = frame_mosi[k];
    end
    for (int k = 0; k < loads; k++) tx_q.push_back(frame_tx[k]);
    if (end_mode != 0) err_exp.push_back(1);
    total_bits = (end_mode == 1) ? nwords * WIDTH + extra : nwords * WIDTH;
    rises = 0;
    waitCycles(2);
    spi_mosi = frame_mosi[0][WIDTH-1];
    spi_cs_n = 1'b0;
    for (int i = 0; i < total_bits; i++) begin
      spi_mosi = frame_mosi[i / WIDTH][WIDTH - 1 - (i % WIDTH)];
      waitCycles(half);
      if (i == 0) checkOutput("frame_active_start", 32'(bus.frame_active), 32'd1);
      if (end_mode == 2 && i == total_bits - 1) begin
        spi_cs_n = 1'b1;
        spi_sclk = 1'b1;
        waitCycles(half);
        spi_sclk = 1'b0;
      end else begin
        spi_sclk = 1'b1;
        rises++;
        if (rises == pause_at) begin
          waitCycles(half);
          ena = 1'b0;
          waitCycles(50);
          ena = 1'b1;
        end
        waitCycles(half);
        if (end_mode == 0 && i == total_bits - 1) spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
      end
    end
    if (end_mode == 1) begin
      waitCycles(half);
      spi_cs_n = 1'b1;
    end
    waitCycles(SYNC_STAGES + 4);
    checkOutput("frame_active_end", 32'(bus.frame_active), 32'd0);
    checkOutput("miso_idle", 32'(spi_miso), 32'd0);
    checkOutput("rx_data_held", 32'(bus.rx_data), 32'(model_last_rx));
    checkOutput("rx_words_missing", 32'(rx_exp.size()), 32'd0);
    checkOutput("miso_words_missing", 32'(miso_exp.size()), 32'd0);
    checkOutput("frame_err_missing", 32'(err_exp.size()), 32'd0);
    checkOutput("tx_fetch_count", 32'(tx_q.size()), 32'd0);
    waitCycles(half);
  endtask

  task automatic sclkPulse(input int half);
    spi_mosi = 1'($urandom);
    waitCycles(half);
    spi_sclk = 1'b1;
    waitCycles(half);
    spi_sclk = 1'b0;
  endtask

  // Register-file model: present the head of tx_q, consume it on tx_load
  initial begin
    bus.tx_data = '0;
    forever begin
      @(negedge clk);
      if (bus.tx_load === 1'b1) begin
        if (tx_q.size() == 0) checkOutput("tx_load_unexpected", 32'd1, 32'd0);
        else void'(tx_q.pop_front());
      end else begin
        bus.tx_data = (tx_q.size() > 0) ? tx_q[0] : '0;
      end
    end
  end

  // Output monitor: rx words, error pulses and one-cycle pulse widths
  initial begin
    logic prev_rxv, prev_err, prev_ld;
    prev_rxv = 1'b0;
    prev_err = 1'b0;
    prev_ld  = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.rx_valid === 1'b1) begin
        checkOutput("rx_valid_width", 32'(prev_rxv), 32'd0);
        if (rx_exp.size() == 0) checkOutput("rx_valid_unexpected", 32'd1, 32'd0);
        else checkOutput("rx_data", 32'(bus.rx_data), 32'(rx_exp.pop_front()));
      end
      if (bus.frame_err === 1'b1) begin
        checkOutput("frame_err_width", 32'(prev_err), 32'd0);
        if (err_exp.size() == 0) checkOutput("frame_err_unexpected", 32'd1, 32'd0);
        else begin
          void'(err_exp.pop_front());
          checkOutput("idle_after_err", 32'(bus.frame_active), 32'd0);
        end
      end
      if (bus.tx_load === 1'b1) checkOutput("tx_load_width", 32'(prev_ld), 32'd0);
      prev_rxv = bus.rx_valid;
      prev_err = bus.frame_err;
      prev_ld  = bus.tx_load;
    end
  end

  // Miso monitor: the master's view, sampled on each sclk rise while selected
  initial begin
    int               mcnt;
    logic [WIDTH-1:0] mword;
    mcnt  = 0;
    mword = '0;
    forever begin
      @(posedge spi_sclk or negedge spi_cs_n);
      if (spi_cs_n == 1'b0 && spi_sclk == 1'b0) begin
        mcnt = 0;
      end else if (spi_cs_n == 1'b0 && spi_sclk == 1'b1) begin
        mword = {mword[WIDTH-2:0], spi_miso};
        mcnt++;
        if (mcnt == WIDTH) begin
          mcnt = 0;
          if (miso_exp.size() == 0) checkOutput("miso_word_unexpected", 32'd1, 32'd0);
          else checkOutput("miso_word", 32'(mword), 32'(miso_exp.pop_front()));
        end
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by randomised frames
  initial begin
    int mode, nw, half, extra, pause;
    rst      = 1'b1;
    ena      = 1'b1;
    spi_cs_n = 1'b1;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    waitCycles(5);
    checkOutput("reset_frame_active", 32'(bus.frame_active), 32'd0);
    checkOutput("reset_miso", 32'(spi_miso), 32'd0);
    rst = 1'b0;
    waitCycles(4);
    checkOutput("reset_rx_valid", 32'(bus.rx_valid), 32'd0);
    checkOutput("reset_rx_data", 32'(bus.rx_data), 32'd0);
    checkOutput("reset_tx_load", 32'(bus.tx_load), 32'd0);
    checkOutput("reset_frame_err", 32'(bus.frame_err), 32'd0);

    $display("[TB] single word");
    frame_mosi[0] = 8'h3C;
    frame_tx[0]   = 8'hA5;
    applyStimulus(1, 8, 0, 0, 0);

    $display("[TB] back-to-back words");
    frame_mosi[0] = 8'h01; frame_mosi[1] = 8'h80; frame_mosi[2] = 8'hFF;
    frame_tx[0]   = 8'h11; frame_tx[1]   = 8'h22; frame_tx[2]   = 8'h33;
    applyStimulus(3, 6, 0, 0, 0);

    $display("[TB] partial frame then full frame");
    frame_mosi[0] = 8'h5A;
    frame_tx[0]   = 8'hC3;
    applyStimulus(0, 6, 1, 5, 0);
    frame_mosi[0] = 8'h96;
    frame_tx[0]   = 8'h69;
    applyStimulus(1, 5, 0, 0, 0);

    $display("[TB] ena gating mid-frame");
    frame_mosi[0] = 8'hB7;
    frame_tx[0]   = 8'h4E;
    applyStimulus(1, 6, 0, 0, 4);

    $display("[TB] reset with cs_n low");
    tx_q.push_back(8'hE1);
    waitCycles(2);
    spi_cs_n = 1'b0;
    repeat (3) sclkPulse(6);
    rst = 1'b1;
    waitCycles(3);
    checkOutput("midframe_reset_active", 32'(bus.frame_active), 32'd0);
    rst = 1'b0;
    model_last_rx = '0;
    repeat (3) sclkPulse(6);
    checkOutput("no_frame_after_reset", 32'(bus.frame_active), 32'd0);
    spi_cs_n = 1'b1;
    waitCycles(8);
    checkOutput("rx_data_after_reset", 32'(bus.rx_data), 32'd0);
    checkOutput("tx_fetch_before_reset", 32'(tx_q.size()), 32'd0);
    frame_mosi[0] = 8'h7E;
    frame_tx[0]   = 8'h81;
    applyStimulus(1, 6, 0, 0, 0);

    $display("[TB] cs_n rise collides with final sclk rise");
    frame_mosi[0] = 8'hD4;
    frame_tx[0]   = 8'h2B;
    applyStimulus(1, 6, 2, 0, 0);

    $display("[TB] randomised frames");
    for (int f = 0; f < 12; f++) begin
      for (int k = 0; k < 8; k++) begin
        frame_mosi[k] = WIDTH'($urandom);
        frame_tx[k]   = WIDTH'($urandom);
      end
      mode  = ($urandom_range(0, 4) < 3) ? 0 : int'($urandom_range(1, 2));
      half  = int'($urandom_range(SYNC_STAGES + 2, 9));
      extra = int'($urandom_range(1, WIDTH - 1));
      nw    = (mode == 1) ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 3));
      pause = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, WIDTH)) : 0;
      applyStimulus(nw, half, mode, extra, pause);
    end

    checkOutput("final_rx_queue", 32'(rx_exp.size()), 32'd0);
    checkOutput("final_tx_queue", 32'(tx_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
